// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, state/type enums and ALU encodings for ctrl_fsm
package ctrl_pkg;

    // Major opcodes recognised by the sequencer
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;

    // alu_op encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_RF  = 2'b10;
    localparam logic [1:0] ALU_IF  = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_RS1   = 3'd1,
        ST_RS2   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_MEM   = 3'd4,
        ST_WB    = 3'd5,
        ST_TRAP  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        IT_R   = 3'd0,
        IT_I   = 3'd1,
        IT_LD  = 3'd2,
        IT_S   = 3'd3,
        IT_B   = 3'd4,
        IT_ILL = 3'd5
    } itype_t;

    // ALU operation selected for each instruction type during EXEC
    function automatic logic [1:0] alu_op_of(input itype_t t);
        case (t)
            IT_R:    return ALU_RF;
            IT_I:    return ALU_IF;
            IT_B:    return ALU_BR;
            default: return ALU_ADD;
        endcase
    endfunction

    // Types that need a second register operand (and therefore an RS2 phase)
    function automatic logic reads_rs2(input itype_t t);
        return (t == IT_R) || (t == IT_S) || (t == IT_B);
    endfunction

    // Types whose B operand is the immediate
    function automatic logic uses_imm(input itype_t t);
        return (t == IT_I) || (t == IT_LD) || (t == IT_S);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational instruction decode: type, register fields, legality
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 5
) (
    input  logic [INSTR_W-1:0] ir,
    output itype_t             itype,
    output logic [REG_AW-1:0]  rs1,
    output logic [REG_AW-1:0]  rs2,
    output logic [REG_AW-1:0]  rd,
    output logic               legal
);

    // funct fields are interpreted by the ALU, not by the sequencer
    logic unused_funct;
    assign unused_funct = ^{ir[INSTR_W-1:25], ir[14:12]};

    // Classify the major opcode; anything unrecognised is illegal
    always_comb begin
        itype = IT_ILL;
        case (ir[6:0])
            OP_R:    itype = IT_R;
            OP_I:    itype = IT_I;
            OP_LD:   itype = IT_LD;
            OP_S:    itype = IT_S;
            OP_B:    itype = IT_B;
            default: itype = IT_ILL;
        endcase
    end

    assign rs1   = ir[15 +: REG_AW];
    assign rs2   = ir[20 +: REG_AW];
    assign rd    = ir[7  +: REG_AW];
    assign legal = (itype != IT_ILL);

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle control sequencer for reg_file; CTRL_PERF_EN adds cycle/retire counters
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 5,
    parameter int PERF_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [REG_AW-1:0]  reg_addr,
    output logic               reg_write,
    output logic               reg_control,
    output logic               mem_to_reg,
    output logic               opa_en,
    output logic               opb_en,
    output logic [1:0]         alu_op,
    output logic               alu_src,
    input  logic               br_cond,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ready,
    output logic               pc_we,
    output logic               pc_src,
    output logic               illegal,
    output logic [PERF_W-1:0]  cyc_cnt,
    output logic [PERF_W-1:0]  ret_cnt
);

    state_t             state;
    state_t             state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] ir_nxt;
    itype_t             ity;
    logic               fetch_fire;
    logic               pc_we_q;
    logic               st_done;

    itype_t             dec_type;
    logic [REG_AW-1:0]  dec_rs1;
    logic [REG_AW-1:0]  dec_rs2;
    logic [REG_AW-1:0]  dec_rd;
    logic               dec_legal;

    // A fetch completes only while the request is actually being driven
    assign fetch_fire = (state == ST_FETCH) && imem_req && imem_valid;

    // IR value for the next cycle; equals ir everywhere except an accepted fetch
    always_comb begin
        ir_nxt = ir;
        if (fetch_fire) begin
            ir_nxt = imem_data;
        end
    end

    // Decode the upcoming IR so every output can be registered for the state it belongs to
    ctrl_decode #(
        .INSTR_W (INSTR_W),
        .REG_AW  (REG_AW)
    ) u_decode (
        .ir    (ir_nxt),
        .itype (dec_type),
        .rs1   (dec_rs1),
        .rs2   (dec_rs2),
        .rd    (dec_rd),
        .legal (dec_legal)
    );

    // Next-state selection; one phase per cycle, MEM waits on dmem_ready
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                if (fetch_fire) begin
                    state_nxt = ST_RS1;
                end
            end
            ST_RS1: begin
                if (!dec_legal) begin
                    state_nxt = ST_TRAP;
                end else if (reads_rs2(dec_type)) begin
                    state_nxt = ST_RS2;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_RS2: state_nxt = ST_EXEC;
            ST_EXEC: begin
                case (dec_type)
                    IT_B:       state_nxt = ST_FETCH;
                    IT_R, IT_I: state_nxt = ST_WB;
                    default:    state_nxt = ST_MEM;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_nxt = (dec_type == IT_S) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB:   state_nxt = ST_FETCH;
            ST_TRAP: state_nxt = ST_TRAP;
            default: state_nxt = ST_FETCH;
        endcase
    end

    // State, IR and registered Moore outputs, loaded with the values of the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            ir          <= '0;
            ity         <= IT_ILL;
            imem_req    <= 1'b0;
            reg_addr    <= '0;
            reg_write   <= 1'b0;
            reg_control <= 1'b0;
            mem_to_reg  <= 1'b0;
            opa_en      <= 1'b0;
            opb_en      <= 1'b0;
            alu_op      <= ALU_ADD;
            alu_src     <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            pc_we_q     <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ir          <= ir_nxt;
            ity         <= dec_type;
            imem_req    <= 1'b0;
            reg_addr    <= '0;
            reg_write   <= 1'b0;
            reg_control <= 1'b0;
            mem_to_reg  <= 1'b0;
            opa_en      <= 1'b0;
            opb_en      <= 1'b0;
            alu_op      <= ALU_ADD;
            alu_src     <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            pc_we_q     <= 1'b0;
            illegal     <= 1'b0;
            case (state_nxt)
                ST_FETCH: imem_req <= 1'b1;
                ST_RS1:   reg_addr <= dec_rs1;
                ST_RS2: begin
                    // rs1 data appears on reg_file out during the cycle after RS1
                    reg_addr <= dec_rs2;
                    opa_en   <= 1'b1;
                end
                ST_EXEC: begin
                    // Two-operand types latch rs2 here; single-operand types latch rs1
                    opb_en  <= reads_rs2(dec_type);
                    opa_en  <= !reads_rs2(dec_type);
                    alu_src <= uses_imm(dec_type);
                    alu_op  <= alu_op_of(dec_type);
                    pc_we_q <= (dec_type == IT_B);
                end
                ST_MEM: begin
                    dmem_req <= 1'b1;
                    dmem_we  <= (dec_type == IT_S);
                end
                ST_WB: begin
                    // Writes to x0 are suppressed but the instruction still retires
                    reg_addr    <= dec_rd;
                    reg_control <= 1'b1;
                    mem_to_reg  <= (dec_type == IT_LD);
                    reg_write   <= (dec_rd != '0);
                    pc_we_q     <= 1'b1;
                end
                ST_TRAP:  illegal <= 1'b1;
                default:  imem_req <= 1'b0;
            endcase
        end
    end

    // Input-qualified strobes use the registered type so no path runs from imem_data
    assign st_done = (state == ST_MEM) && (ity == IT_S) && dmem_ready;
    assign pc_we   = pc_we_q | st_done;
    assign pc_src  = (state == ST_EXEC) && (ity == IT_B) && br_cond;

`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] cyc_q;
    logic [PERF_W-1:0] ret_q;

    // Free-running cycle count and retirement count, both wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + PERF_W'(1);
            if (pc_we) begin
                ret_q <= ret_q + PERF_W'(1);
            end
        end
    end

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`else
    assign cyc_cnt = '0;
    assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - directed self-checking bench for ctrl_fsm
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = '0;
    logic [4:0]  reg_addr;
    logic        reg_write;
    logic        reg_control;
    logic        mem_to_reg;
    logic        opa_en;
    logic        opb_en;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        br_cond = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready = 1'b0;
    logic        pc_we;
    logic        pc_src;
    logic        illegal;
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADDI = 32'h00100013;
    localparam logic [31:0] I_LD   = 32'h00813303;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    // Bit positions in the observed output vector
    localparam logic [18:0] IREQ = 19'h40000;
    localparam logic [18:0] RW   = 19'h01000;
    localparam logic [18:0] RC   = 19'h00800;
    localparam logic [18:0] M2R  = 19'h00400;
    localparam logic [18:0] OA   = 19'h00200;
    localparam logic [18:0] OB   = 19'h00100;
    localparam logic [18:0] ASRC = 19'h00020;
    localparam logic [18:0] DREQ = 19'h00010;
    localparam logic [18:0] DWE  = 19'h00008;
    localparam logic [18:0] PW   = 19'h00004;
    localparam logic [18:0] PS   = 19'h00002;
    localparam logic [18:0] ILL  = 19'h00001;

`ifdef CTRL_PERF_EN
    localparam logic [31:0] EXP_CYC = 32'd5;
    localparam logic [31:0] EXP_RET = 32'd1;
`else
    localparam logic [31:0] EXP_CYC = 32'd0;
    localparam logic [31:0] EXP_RET = 32'd0;
`endif

    ctrl_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .reg_addr    (reg_addr),
        .reg_write   (reg_write),
        .reg_control (reg_control),
        .mem_to_reg  (mem_to_reg),
        .opa_en      (opa_en),
        .opb_en      (opb_en),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .br_cond     (br_cond),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .illegal     (illegal),
        .cyc_cnt     (cyc_cnt),
        .ret_cnt     (ret_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] adr(input logic [4:0] a);
        return {1'b0, a, 13'd0};
    endfunction

    function automatic logic [18:0] aop(input logic [1:0] o);
        return {11'd0, o, 6'd0};
    endfunction

    function automatic logic [18:0] obs();
        return {imem_req, reg_addr, reg_write, reg_control, mem_to_reg, opa_en, opb_en,
                alu_op, alu_src, dmem_req, dmem_we, pc_we, pc_src, illegal};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (obs() !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %05h want %05h", obs(), 19'd0);
        end
        n_cmp++;
        if (cyc_cnt !== 32'd0 || ret_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got cyc=%0d ret=%0d want 0 0", cyc_cnt, ret_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs() !== IREQ) begin
            n_fail++;
            $display("FAIL reset_release: got %05h want %05h", obs(), IREQ);
        end
    endtask

    task automatic test_add();
        logic [18:0] ev [6];
        int pcw = 0;
        ev[0] = IREQ;
        ev[1] = adr(5'd1);
        ev[2] = adr(5'd2) | OA;
        ev[3] = OB | aop(2'b10);
        ev[4] = adr(5'd3) | RW | RC | PW;
        ev[5] = IREQ;
        imem_data = I_ADD;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            imem_valid = (c == 0);
            #1;
            n_cmp++;
            if (obs() !== ev[c]) begin
                n_fail++;
                $display("FAIL add_cyc%0d: got %05h want %05h", c, obs(), ev[c]);
            end
            if (pc_we) pcw++;
        end
        n_cmp++;
        if (pcw !== 1) begin
            n_fail++;
            $display("FAIL add_pc_we_count: got %0d want 1", pcw);
        end
    endtask

    task automatic test_addi_x0();
        logic [18:0] ev [5];
        ev[0] = IREQ;
        ev[1] = adr(5'd0);
        ev[2] = OA | aop(2'b11) | ASRC;
        ev[3] = RC | PW;
        ev[4] = IREQ;
        imem_data = I_ADDI;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            imem_valid = (c == 0);
            #1;
            n_cmp++;
            if (obs() !== ev[c]) begin
                n_fail++;
                $display("FAIL addi_cyc%0d: got %05h want %05h", c, obs(), ev[c]);
            end
        end
    endtask

    task automatic test_load_wait();
        logic [18:0] ev [9];
        int pcw = 0;
        ev[0] = IREQ;
        ev[1] = adr(5'd2);
        ev[2] = OA | ASRC;
        ev[3] = DREQ;
        ev[4] = DREQ;
        ev[5] = DREQ;
        ev[6] = DREQ;
        ev[7] = adr(5'd6) | RW | RC | M2R | PW;
        ev[8] = IREQ;
        imem_data = I_LD;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            imem_valid = (c == 0);
            dmem_ready = (c == 6);
            #1;
            n_cmp++;
            if (obs() !== ev[c]) begin
                n_fail++;
                $display("FAIL ld_cyc%0d: got %05h want %05h", c, obs(), ev[c]);
            end
            if (pc_we) pcw++;
        end
        dmem_ready = 1'b0;
        n_cmp++;
        if (pcw !== 1) begin
            n_fail++;
            $display("FAIL ld_pc_we_count: got %0d want 1", pcw);
        end
    endtask

    task automatic test_branch(input logic bc);
        logic [18:0] ev [5];
        ev[0] = IREQ;
        ev[1] = adr(5'd1);
        ev[2] = adr(5'd2) | OA;
        ev[3] = OB | aop(2'b01) | PW | (bc ? PS : 19'd0);
        ev[4] = IREQ;
        imem_data = I_BEQ;
        br_cond = bc;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            imem_valid = (c == 0);
            #1;
            n_cmp++;
            if (obs() !== ev[c]) begin
                n_fail++;
                $display("FAIL beq%0d_cyc%0d: got %05h want %05h", bc, c, obs(), ev[c]);
            end
        end
        br_cond = 1'b0;
    endtask

    task automatic test_store();
        logic [18:0] ev [6];
        ev[0] = IREQ;
        ev[1] = adr(5'd1);
        ev[2] = adr(5'd2) | OA;
        ev[3] = OB | ASRC;
        ev[4] = DREQ | DWE | PW;
        ev[5] = IREQ;
        imem_data = I_SW;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            imem_valid = (c == 0);
            dmem_ready = (c == 4);
            #1;
            n_cmp++;
            if (obs() !== ev[c]) begin
                n_fail++;
                $display("FAIL sw_cyc%0d: got %05h want %05h", c, obs(), ev[c]);
            end
        end
        dmem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [18:0] ev [10];
        int pcw = 0;
        ev[0] = IREQ;
        ev[1] = adr(5'd0);
        ev[2] = OA | aop(2'b11) | ASRC;
        ev[3] = RC | PW;
        ev[4] = IREQ;
        ev[5] = adr(5'd1);
        ev[6] = adr(5'd2) | OA;
        ev[7] = OB | aop(2'b10);
        ev[8] = adr(5'd3) | RW | RC | PW;
        ev[9] = IREQ;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            imem_data  = (c < 4) ? I_ADDI : I_ADD;
            imem_valid = (c == 0) || (c == 4);
            #1;
            n_cmp++;
            if (obs() !== ev[c]) begin
                n_fail++;
                $display("FAIL b2b_cyc%0d: got %05h want %05h", c, obs(), ev[c]);
            end
            if (pc_we) pcw++;
        end
        n_cmp++;
        if (pcw !== 2) begin
            n_fail++;
            $display("FAIL b2b_pc_we_count: got %0d want 2", pcw);
        end
    endtask

    task automatic test_illegal();
        logic [18:0] ev [6];
        ev[0] = IREQ;
        ev[1] = adr(5'd31);
        ev[2] = ILL;
        ev[3] = ILL;
        ev[4] = ILL;
        ev[5] = ILL;
        imem_data = I_BAD;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            imem_valid = 1'b1;
            #1;
            n_cmp++;
            if (obs() !== ev[c]) begin
                n_fail++;
                $display("FAIL trap_cyc%0d: got %05h want %05h", c, obs(), ev[c]);
            end
        end
        @(negedge clk);
        imem_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 19'd0) begin
            n_fail++;
            $display("FAIL trap_reset: got %05h want %05h", obs(), 19'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs() !== IREQ) begin
            n_fail++;
            $display("FAIL trap_refetch: got %05h want %05h", obs(), IREQ);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [18:0] ev [6];
        ev[0] = IREQ;
        ev[1] = adr(5'd1);
        ev[2] = adr(5'd2) | OA;
        ev[3] = OB | ASRC;
        ev[4] = DREQ | DWE;
        ev[5] = DREQ | DWE;
        imem_data = I_SW;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            imem_valid = (c == 0);
            dmem_ready = 1'b0;
            #1;
            n_cmp++;
            if (obs() !== ev[c]) begin
                n_fail++;
                $display("FAIL swrst_cyc%0d: got %05h want %05h", c, obs(), ev[c]);
            end
        end
        @(negedge clk);
        dmem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 19'd0) begin
            n_fail++;
            $display("FAIL swrst_clear: got %05h want %05h", obs(), 19'd0);
        end
        n_cmp++;
        if (cyc_cnt !== 32'd0 || ret_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL swrst_counters: got cyc=%0d ret=%0d want 0 0", cyc_cnt, ret_cnt);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (obs() !== 19'd0) begin
                n_fail++;
                $display("FAIL swrst_hold%0d: got %05h want %05h", c, obs(), 19'd0);
            end
        end
        @(negedge clk);
        dmem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs() !== IREQ) begin
            n_fail++;
            $display("FAIL swrst_refetch: got %05h want %05h", obs(), IREQ);
        end
    endtask

    task automatic test_perf();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        imem_data = I_ADDI;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            imem_valid = (c == 0);
        end
        @(negedge clk);
        imem_valid = 1'b0;
        #1;
        n_cmp++;
        if (cyc_cnt !== EXP_CYC) begin
            n_fail++;
            $display("FAIL perf_cyc: got %0d want %0d", cyc_cnt, EXP_CYC);
        end
        n_cmp++;
        if (ret_cnt !== EXP_RET) begin
            n_fail++;
            $display("FAIL perf_ret: got %0d want %0d", ret_cnt, EXP_RET);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi_x0();
        test_load_wait();
        test_branch(1'b1);
        test_branch(1'b0);
        test_store();
        test_back_to_back();
        test_illegal();
        test_reset_mid_store();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
- Multi-cycle control sequencer sitting directly upstream of reg_file.
- Fetches one 32-bit instruction, decodes R/I/LD/S/B types, and drives reg_file's single `address` port plus its `write`, `control` and `MemToReg` strobes, ALU and memory controls, and PC update, one phase per cycle.
- Serialises rs1 read, rs2 read and rd write-back because reg_file has one address port and registered read data (`hold` updates on posedge).

Parameters:
- INSTR_W, 32, instruction width.
- REG_AW, 5, register address width.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_valid  in  1  instruction data valid.
- imem_data  in  INSTR_W  fetched instruction.
- reg_addr  out  REG_AW  to reg_file address.
- reg_write  out  1  to reg_file write.
- reg_control  out  1  to reg_file control.
- mem_to_reg  out  1  to reg_file MemToReg.
- opa_en  out  1  latch reg_file out as operand A.
- opb_en  out  1  latch reg_file out as operand B.
- alu_op  out  2  00 add (LD/S), 01 branch compare, 10 R funct, 11 I funct.
- alu_src  out  1  1 = immediate as B.
- br_cond  in  1  branch condition true (from ALU, valid in EXEC).
- dmem_req  out  1  data memory request.
- dmem_we  out  1  store when 1.
- dmem_ready  in  1  data access complete.
- pc_we  out  1  PC update pulse.
- pc_src  out  1  1 = branch target, 0 = PC+4.
- illegal  out  1  sticky unsupported-opcode flag.
- cyc_cnt  out  PERF_W  cycle counter (optional feature).
- ret_cnt  out  PERF_W  retired instructions (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - State goes to FETCH; the internal IR clears to 0.
  - All outputs are 0 except imem_req, which goes to 1 once rst_n deasserts.
  - Reset mid-instruction abandons it with no reg_file write and no pc_we.
- Opcodes: R 0110011, I 0010011, LD 0000011, S 0100011, B 1100011. Anything else is illegal.
- States: FETCH, RS1, RS2, EXEC, MEM, WB, TRAP. Outputs are Moore-decoded from state plus IR; none depend combinationally on imem_data.
- FETCH: imem_req=1. On imem_valid, IR<=imem_data and go to RS1; otherwise stay.
- RS1:
  - reg_addr=IR[19:15], reg_write=0.
  - Illegal opcode goes to TRAP.
  - I/LD go to EXEC; R/S/B go to RS2.
- RS2: reg_addr=IR[24:20], reg_write=0, opa_en=1. Go to EXEC.
- EXEC:
  - opb_en=1 for R/S/B. opa_en=1 for I/LD, whose preceding state was RS1.
  - alu_src=1 for I/LD/S. alu_op per type.
  - B: pc_we=1, pc_src=br_cond, go to FETCH.
  - R/I go to WB; LD/S go to MEM.
- MEM:
  - dmem_req=1; dmem_we=1 for S.
  - Hold until dmem_ready.
  - S: pc_we=1 in the ready cycle, go to FETCH. LD goes to WB.
- WB:
  - reg_addr=IR[11:7], reg_control=1, mem_to_reg=1 for LD.
  - reg_write=1 unless rd==0, which suppresses the x0 write; pc_we=1 regardless.
  - Go to FETCH.
- TRAP: all outputs 0, illegal=1. Only reset exits.
- Minimum latency (zero-wait memories): I 4, B 4, R 5, S 5, LD 5 cycles.
- Exactly one pc_we per retired instruction.
- Unused address cycles drive reg_addr=0.

Optional Feature:
- Macro CTRL_PERF_EN.
- Defined:
  - cyc_cnt increments every cycle out of reset.
  - ret_cnt increments on each pc_we.
  - Both counters wrap modulo 2^PERF_W and reset to 0 asynchronously.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LD, OP_S, OP_B);
  - the state enum;
  - alu_op encodings (ALU_ADD, ALU_BR, ALU_RF, ALU_IF).
- One sub-module, ctrl_decode: combinational IR to {type, rs1, rs2, rd, legal}.

Test Plan:
- add x3,x1,x2 (0x002081B3), imem_valid in cycle 1:
  - reg_addr 1, 2, -, 3 in RS1, RS2, EXEC, WB.
  - opa_en in RS2, opb_en in EXEC, alu_op=10.
  - reg_write=1 with reg_control=1, mem_to_reg=0 in WB; pc_we once; 5 cycles total.
- addi x0,x0,1 (0x00100013): 4 cycles, reg_write stays 0 in WB, pc_we=1, pc_src=0.
- ld x6,8(x2) (0x00813303), dmem_ready delayed 3 cycles:
  - MEM held 3 cycles with dmem_we=0.
  - Then WB with reg_addr=6, mem_to_reg=1, reg_write=1; 8 cycles total.
- beq x1,x2,+8 (0x00208463): br_cond=1 gives pc_we=1, pc_src=1 in EXEC; br_cond=0 gives pc_src=0; no reg write either way.
- 0xFFFFFFFF fetched: TRAP after RS1, illegal=1, imem_req=0 forever. rst_n pulse returns to FETCH with illegal=0.
- rst_n low during the MEM of a store:
  - No pc_we is issued.
  - Outputs clear immediately.
  - Restart refetches with imem_req=1.
  - With CTRL_PERF_EN, cyc_cnt and ret_cnt read 0 after reset.
